// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, and feeds the IF/ID slot through a 1-entry skid buffer.
// EX redirects flush the stage. A response that was already in flight when
// the redirect arrived is discarded through the DROP state.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DROP = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] pc_r, pc_nxt_s;
  logic [XLEN-1:0] req_pc_r, req_pc_nxt_s;
  logic            id_valid_r, id_valid_nxt_s;
  logic [XLEN-1:0] id_instr_r, id_instr_nxt_s;
  logic [XLEN-1:0] id_pc_r, id_pc_nxt_s;
  logic            skid_full_r, skid_full_nxt_s;
  logic [XLEN-1:0] skid_instr_r, skid_instr_nxt_s;
  logic [XLEN-1:0] skid_pc_r, skid_pc_nxt_s;
  logic            slot_free_s;
  logic            issue_s;
  logic            resp_s;

  // Next-state and datapath decisions; a redirect overrides every other action.
  always_comb begin
    slot_free_s      = !id_valid_r || !stall;
    issue_s          = 1'b0;
    resp_s           = 1'b0;
    state_nxt_s      = state_r;
    pc_nxt_s         = pc_r;
    req_pc_nxt_s     = req_pc_r;
    id_valid_nxt_s   = id_valid_r;
    id_instr_nxt_s   = id_instr_r;
    id_pc_nxt_s      = id_pc_r;
    skid_full_nxt_s  = skid_full_r;
    skid_instr_nxt_s = skid_instr_r;
    skid_pc_nxt_s    = skid_pc_r;

    if (redirect_valid) begin
      pc_nxt_s        = {redirect_pc[XLEN-1:2], 2'b00};
      id_valid_nxt_s  = 1'b0;
      id_instr_nxt_s  = NOP_INSTR;
      skid_full_nxt_s = 1'b0;
      // An in-flight request that has not answered yet must be dropped later.
      case (state_r)
        WAIT, DROP: state_nxt_s = imem_rvalid ? IDLE : DROP;
        default:    state_nxt_s = IDLE;
      endcase
    end else begin
      issue_s = !skid_full_r &&
                ((state_r == IDLE) || ((state_r == WAIT) && imem_rvalid && slot_free_s));
      resp_s  = (state_r == WAIT) && imem_rvalid;

      if (issue_s) begin
        pc_nxt_s     = pc_r + PC_STEP;
        req_pc_nxt_s = pc_r;
      end else begin
        pc_nxt_s     = pc_r;
        req_pc_nxt_s = req_pc_r;
      end

      case (state_r)
        IDLE:    state_nxt_s = issue_s ? WAIT : IDLE;
        WAIT:    state_nxt_s = imem_rvalid ? (issue_s ? WAIT : IDLE) : WAIT;
        DROP:    state_nxt_s = imem_rvalid ? IDLE : DROP;
        default: state_nxt_s = IDLE;
      endcase

      // The id slot is refilled from the response first, then from the skid.
      if (resp_s && slot_free_s) begin
        id_valid_nxt_s = 1'b1;
        id_instr_nxt_s = imem_rdata;
        id_pc_nxt_s    = req_pc_r;
      end else if (skid_full_r && slot_free_s) begin
        id_valid_nxt_s = 1'b1;
        id_instr_nxt_s = skid_instr_r;
        id_pc_nxt_s    = skid_pc_r;
      end else if (id_valid_r && !stall) begin
        id_valid_nxt_s = 1'b0;
        id_instr_nxt_s = NOP_INSTR;
        id_pc_nxt_s    = id_pc_r;
      end else begin
        id_valid_nxt_s = id_valid_r;
        id_instr_nxt_s = id_instr_r;
        id_pc_nxt_s    = id_pc_r;
      end

      // A response that cannot enter a stalled slot parks in the skid buffer.
      if (resp_s && !slot_free_s) begin
        skid_full_nxt_s  = 1'b1;
        skid_instr_nxt_s = imem_rdata;
        skid_pc_nxt_s    = req_pc_r;
      end else if (skid_full_r && slot_free_s) begin
        skid_full_nxt_s  = 1'b0;
      end else begin
        skid_full_nxt_s  = skid_full_r;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      req_pc_r     <= RESET_PC;
      id_valid_r   <= 1'b0;
      id_instr_r   <= NOP_INSTR;
      id_pc_r      <= RESET_PC;
      skid_full_r  <= 1'b0;
      skid_instr_r <= NOP_INSTR;
      skid_pc_r    <= RESET_PC;
    end else begin
      state_r      <= state_nxt_s;
      pc_r         <= pc_nxt_s;
      req_pc_r     <= req_pc_nxt_s;
      id_valid_r   <= id_valid_nxt_s;
      id_instr_r   <= id_instr_nxt_s;
      id_pc_r      <= id_pc_nxt_s;
      skid_full_r  <= skid_full_nxt_s;
      skid_instr_r <= skid_instr_nxt_s;
      skid_pc_r    <= skid_pc_nxt_s;
    end
  end

  // The request strobe is combinational so the memory sees it in the issue
  // cycle. It is gated by reset because IDLE would otherwise issue at once.
  assign imem_req    = issue_s && !reset;
  assign imem_addr   = pc_r;
  assign id_valid    = id_valid_r;
  assign id_instr    = id_instr_r;
  assign id_pc       = id_pc_r;
  assign id_pc_plus4 = id_pc_r + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. An instruction-memory model with variable latency
// runs alongside the DUT. A program-order model tracks the next fetch address
// and the next instruction decode must see. Directed sequences pin the timing.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // stimulus controls set by the main sequence
  logic        rand_mode = 1'b0;
  logic        scramble  = 1'b0;
  logic        dir_stall = 1'b0;
  logic        dir_redir = 1'b0;
  logic [31:0] dir_rpc   = 32'h0;
  int          mem_lat   = 1;

  // memory and program-order model state
  logic        mem_busy  = 1'b0;
  logic        stale     = 1'b0;
  logic        late_rv   = 1'b0;
  int          mem_cnt   = 0;
  logic [31:0] mem_addr  = 32'h0;
  logic [31:0] exp_fetch = 32'h0;
  logic [31:0] exp_id    = 32'h0;
  logic        prev_hold = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return scramble ? (a ^ 32'h5A3C_96E1) : a;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFE0 | ($urandom & 32'h0000_001F);
    return $urandom & 32'h0000_3FFF;
  endfunction

  // Per-cycle engine: drives memory responses and control inputs at the
  // falling edge, then checks the settled outputs against the model.
  initial begin : engine
    logic resp_now, late_now, ok_slot;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (mem_busy) late_rv = 1'b1;
        mem_busy       = 1'b0;
        stale          = 1'b0;
        exp_fetch      = 32'h0;
        exp_id         = 32'h0;
        prev_hold      = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
      end else begin
        late_now    = late_rv;
        late_rv     = 1'b0;
        resp_now    = mem_busy && (mem_cnt == 1);
        imem_rvalid = late_now || resp_now;
        imem_rdata  = resp_now ? mem_word(mem_addr) : 32'hDEAD_BEEF;
        if (late_now)
          $display("note: imem_rvalid with no outstanding request (protocol violation, injected after reset)");
        if (rand_mode) begin
          stall          = ($urandom_range(0, 3) == 0);
          redirect_valid = ($urandom_range(0, 24) == 0);
          redirect_pc    = rand_target();
        end else begin
          stall          = dir_stall;
          redirect_valid = dir_redir;
          redirect_pc    = dir_rpc;
        end
        #3;
        ok_slot = !mem_busy || (resp_now && !stale);
        check("req_vs_redirect", {31'd0, imem_req && redirect_valid}, 32'd0);
        check("req_while_outstanding", {31'd0, imem_req && !ok_slot}, 32'd0);
        if (imem_req) check("fetch_addr", imem_addr, exp_fetch);
        if (prev_hold) check("stall_hold_valid", {31'd0, id_valid}, 32'd1);
        if (id_valid) begin
          check("id_pc", id_pc, exp_id);
          check("id_instr", id_instr, mem_word(exp_id));
          check("id_pc_plus4", id_pc_plus4, exp_id + 32'd4);
        end else begin
          check("nop_when_invalid", id_instr, NOP);
        end
        // program-order model update
        if (redirect_valid) begin
          exp_fetch = {redirect_pc[31:2], 2'b00};
          exp_id    = {redirect_pc[31:2], 2'b00};
          if (mem_busy && !resp_now) stale = 1'b1;
        end else begin
          if (id_valid && !stall) begin
            exp_id = exp_id + 32'd4;
            n_deliv++;
          end
          if (imem_req) exp_fetch = exp_fetch + 32'd4;
        end
        prev_hold = id_valid && stall && !redirect_valid;
        // memory model update
        if (resp_now) begin
          mem_busy = 1'b0;
          stale    = 1'b0;
        end else if (mem_busy) begin
          mem_cnt--;
        end
        if (imem_req) begin
          mem_busy = 1'b1;
          mem_addr = imem_addr;
          mem_cnt  = rand_mode ? int'($urandom_range(1, 3)) : mem_lat;
        end
      end
    end
  end

  task automatic wait_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #4;
  endtask

  // Asserts reset between clock edges, checks reset values, releases it
  // just after a rising edge so the following cycle is cycle 0.
  task automatic apply_reset(input logic scr);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 32'h0000_0000);
    check("rst_id_pc_plus4", id_pc_plus4, 32'h0000_0004);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    scramble = scr;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;

    // Throughput from reset with 1-cycle memory, then a 3-cycle stall.
    mem_lat = 1;
    apply_reset(1'b0);
    wait_neg(); check("c0_req", {31'd0, imem_req}, 32'd1); check("c0_addr", imem_addr, 32'h0);
    wait_pos(); check("e1_valid", {31'd0, id_valid}, 32'd0);
    wait_neg(); check("c1_addr", imem_addr, 32'h4);
    wait_pos(); check("e2_valid", {31'd0, id_valid}, 32'd1);
    check("e2_pc", id_pc, 32'h0); check("e2_instr", id_instr, 32'h0);
    check("e2_pc4", id_pc_plus4, 32'h4);
    wait_pos(); check("e3_pc", id_pc, 32'h4);
    wait_pos(); check("e4_pc", id_pc, 32'h8);
    dir_stall = 1'b1;
    wait_neg(); check("stall_c4_req", {31'd0, imem_req}, 32'd0);
    wait_neg(); check("stall_c5_req", {31'd0, imem_req}, 32'd0);
    wait_neg(); check("stall_c6_req", {31'd0, imem_req}, 32'd0);
    dir_stall = 1'b0;
    wait_pos(); check("stall_e7_pc", id_pc, 32'h8);
    wait_neg(); check("skid_full_req", {31'd0, imem_req}, 32'd0);
    wait_pos(); check("skid_drain_pc", id_pc, 32'hC); check("skid_drain_instr", id_instr, 32'hC);
    wait_neg(); check("resume_req", {31'd0, imem_req}, 32'd1); check("resume_addr", imem_addr, 32'h10);
    repeat (3) wait_pos();

    // Async reset mid-WAIT with id valid; a late rvalid must be ignored.
    apply_reset(1'b0);
    wait_neg(); check("late_c0_req", {31'd0, imem_req}, 32'd1); check("late_c0_addr", imem_addr, 32'h0);
    wait_pos();
    wait_neg(); check("late_c1_addr", imem_addr, 32'h4);
    wait_pos(); check("late_e2_valid", {31'd0, id_valid}, 32'd1); check("late_e2_instr", id_instr, 32'h0);

    // Redirect while WAIT, 3-cycle memory: the stale response is dropped.
    mem_lat = 3;
    apply_reset(1'b0);
    wait_neg(); check("drop_c0_addr", imem_addr, 32'h0);
    dir_redir = 1'b1; dir_rpc = 32'h0000_0100;
    wait_neg(); check("drop_c1_req", {31'd0, imem_req}, 32'd0);
    dir_redir = 1'b0;
    wait_neg(); check("drop_c2_req", {31'd0, imem_req}, 32'd0);
    wait_neg(); check("drop_c3_req", {31'd0, imem_req}, 32'd0);
    wait_pos(); check("drop_e4_valid", {31'd0, id_valid}, 32'd0);
    wait_neg(); check("drop_c4_req", {31'd0, imem_req}, 32'd1); check("drop_c4_addr", imem_addr, 32'h100);
    wait_pos(); wait_pos();
    wait_pos(); check("drop_e7_valid", {31'd0, id_valid}, 32'd0);
    wait_pos(); check("drop_e8_valid", {31'd0, id_valid}, 32'd1);
    check("drop_e8_pc", id_pc, 32'h100); check("drop_e8_instr", id_instr, 32'h100);

    // Redirect coincident with rvalid, unaligned target 0x203.
    mem_lat = 1;
    apply_reset(1'b0);
    wait_neg();
    dir_redir = 1'b1; dir_rpc = 32'h0000_0203;
    wait_neg(); check("coinc_c1_req", {31'd0, imem_req}, 32'd0);
    dir_redir = 1'b0;
    wait_pos(); check("coinc_e2_valid", {31'd0, id_valid}, 32'd0);
    wait_neg(); check("coinc_c2_req", {31'd0, imem_req}, 32'd1); check("coinc_c2_addr", imem_addr, 32'h200);
    wait_pos(); wait_pos(); check("coinc_e4_pc", id_pc, 32'h200);

    // PC wrap: redirect to 0xFFFF_FFFE fetches 0xFFFF_FFFC then 0.
    apply_reset(1'b0);
    wait_neg();
    dir_redir = 1'b1; dir_rpc = 32'hFFFF_FFFE;
    wait_neg();
    dir_redir = 1'b0;
    wait_neg(); check("wrap_c2_addr", imem_addr, 32'hFFFF_FFFC);
    wait_neg(); check("wrap_c3_req", {31'd0, imem_req}, 32'd1); check("wrap_c3_addr", imem_addr, 32'h0);
    wait_pos(); check("wrap_e4_pc", id_pc, 32'hFFFF_FFFC); check("wrap_e4_pc4", id_pc_plus4, 32'h0);

    // Randomized stall/redirect/latency traffic against the model.
    apply_reset(1'b1);
    n_deliv   = 0;
    rand_mode = 1'b1;
    repeat (3000) @(posedge clk);
    #1;
    rand_mode = 1'b0;
    check("random_progress", {31'd0, n_deliv >= 300}, 32'd1);
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
